// File: rtl/tick_generator_pkg.sv
// tick_generator_pkg
// Shared defaults for the stopwatch tick source and the divisor clamp helper.
// No ports; imported by tick_generator and tick_stage.
package tick_generator_pkg;

  localparam int DEF_DIV       = 1000000;
  localparam int DEF_STAGE_DIV = 10;
  localparam int DEF_STAGE_W   = 4;

  // A zero divisor would mean "tick never" with the >= comparator never
  // reaching a sensible period, so it is treated as divide-by-one.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/tick_generator_if.sv
// tick_generator_if
// Control and tick bundle of the tick source.
//   enable, clear, load, div_in      : control, driven by the master
//   base_tick, stage_tick, sq_out,
//   cur_count                        : tick outputs, driven by the slave
interface tick_generator_if #(
  parameter int WIDTH      = 20,
  parameter int NUM_STAGES = 3
);

  logic                  enable;
  logic                  clear;
  logic                  load;
  logic [WIDTH-1:0]      div_in;
  logic                  base_tick;
  logic [NUM_STAGES-1:0] stage_tick;
  logic                  sq_out;
  logic [WIDTH-1:0]      cur_count;

  modport master (
    output enable, clear, load, div_in,
    input  base_tick, stage_tick, sq_out, cur_count
  );

  modport slave (
    input  enable, clear, load, div_in,
    output base_tick, stage_tick, sq_out, cur_count
  );

endinterface

// File: rtl/tick_generator_tick_stage.sv
// tick_stage
// One decimal-style stage of the cascade: counts carry_in pulses and wraps
// after STAGE_DIV of them.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : synchronous restart of the count
//   carry_in     : advance request from the previous stage (or base wrap)
//   carry_out    : combinational, set when this stage wraps this cycle
//   tick         : registered carry_out, aligned with the base_tick it completes
module tick_stage
  import tick_generator_pkg::*;
#(
  parameter int STAGE_DIV = DEF_STAGE_DIV,
  parameter int STAGE_W   = DEF_STAGE_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic carry_in,
  output logic carry_out,
  output logic tick
);

  localparam logic [STAGE_W-1:0] LAST = STAGE_W'(STAGE_DIV - 1);

  logic [STAGE_W-1:0] count;

  // >= keeps the stage self-recovering should count ever exceed LAST.
  assign carry_out = carry_in && (count >= LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= carry_out;
      if (carry_in) begin
        count <= carry_out ? '0 : count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_generator.sv
// tick_generator
// Programmable divider producing a single-cycle base tick, a cascade of
// NUM_STAGES stage ticks and a 50 % square wave.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : enable, clear, load, div_in in;
//                  base_tick, stage_tick, sq_out, cur_count out
module tick_generator
  import tick_generator_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DIV   = DEF_STAGE_DIV,
  parameter int STAGE_W     = DEF_STAGE_W
) (
  input logic            clock,
  input logic            reset,
  tick_generator_if.slave bus
);

  logic [WIDTH-1:0]      div_active;
  logic [WIDTH-1:0]      cnt;
  logic                  base_tick_q;
  logic                  sq_q;
  logic                  restart;
  logic                  advance;
  logic                  wrap;
  logic [NUM_STAGES:0]   carry;
  logic [NUM_STAGES-1:0] stage_tick_q;
  logic                  chain_unused;

  // clear and load both restart the counters and take priority over enable.
  assign restart  = bus.clear | bus.load;
  assign advance  = bus.enable & ~restart;

  // >= rather than == so an out-of-range cnt still wraps on the next cycle.
  assign wrap     = (cnt >= div_active - WIDTH'(1));
  assign carry[0] = advance & wrap;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    tick_stage #(
      .STAGE_DIV (STAGE_DIV),
      .STAGE_W   (STAGE_W)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .clear     (restart),
      .carry_in  (carry[g]),
      .carry_out (carry[g+1]),
      .tick      (stage_tick_q[g])
    );
  end

  // The carry out of the last stage has no consumer.
  assign chain_unused = carry[NUM_STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      div_active  <= WIDTH'(DEFAULT_DIV);
      cnt         <= '0;
      base_tick_q <= 1'b0;
      sq_q        <= 1'b0;
    end else if (restart) begin
      if (bus.load) begin
        div_active <= WIDTH'(clamp_div(32'(bus.div_in)));
      end
      cnt         <= '0;
      base_tick_q <= 1'b0;
      // load alone leaves the square wave phase untouched.
      if (bus.clear) begin
        sq_q <= 1'b0;
      end
    end else if (bus.enable) begin
      if (wrap) begin
        cnt         <= '0;
        base_tick_q <= 1'b1;
        sq_q        <= ~sq_q;
      end else begin
        cnt         <= cnt + 1'b1;
        base_tick_q <= 1'b0;
      end
    end else begin
      base_tick_q <= 1'b0;
    end
  end

  assign bus.base_tick  = base_tick_q;
  assign bus.stage_tick = stage_tick_q;
  assign bus.sq_out     = sq_q;
  assign bus.cur_count  = cnt;

endmodule

// File: tb/tb_tick_generator.sv
module tb_tick_generator;

  localparam int W    = 8;
  localparam int DDIV = 5;
  localparam int NS   = 2;
  localparam int SDIV = 3;
  localparam int SW   = 2;

  logic clock;
  logic reset;

  tick_generator_if #(.WIDTH(W), .NUM_STAGES(NS)) bus ();

  tick_generator #(
    .WIDTH       (W),
    .DEFAULT_DIV (DDIV),
    .NUM_STAGES  (NS),
    .STAGE_DIV   (SDIV),
    .STAGE_W     (SW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed enabled cycles since the last restart; the
  // counter, tick and stage tick values follow from division arithmetic.
  int          m_div;
  int          m_elapsed;
  logic        m_sq;
  logic        exp_base;
  logic [NS-1:0] exp_stage;
  int          exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit clr, input bit ld, input int din);
    int nt;
    int p;
    reset      = rst;
    bus.enable = en;
    bus.clear  = clr;
    bus.load   = ld;
    bus.div_in = W'(din);
    if (rst) begin
      m_div = DDIV; m_elapsed = 0; m_sq = 1'b0;
      exp_base = 1'b0; exp_stage = '0;
    end else if (clr || ld) begin
      if (ld) m_div = ((din % 256) == 0) ? 1 : (din % 256);
      if (clr) m_sq = 1'b0;
      m_elapsed = 0;
      exp_base = 1'b0; exp_stage = '0;
    end else if (en) begin
      m_elapsed++;
      if (m_elapsed % m_div == 0) begin
        exp_base = 1'b1;
        m_sq = ~m_sq;
        nt = m_elapsed / m_div;
        p = 1;
        for (int k = 0; k < NS; k++) begin
          p = p * SDIV;
          exp_stage[k] = ((nt % p) == 0);
        end
      end else begin
        exp_base = 1'b0; exp_stage = '0;
      end
    end else begin
      exp_base = 1'b0; exp_stage = '0;
    end
    exp_cnt = m_elapsed % m_div;
    @(posedge clock);
    #1;
    chk("base_tick",  32'(bus.base_tick),  32'(exp_base));
    chk("stage_tick", 32'(bus.stage_tick), 32'(exp_stage));
    chk("sq_out",     32'(bus.sq_out),     32'(m_sq));
    chk("cur_count",  32'(bus.cur_count),  32'(exp_cnt));
    reset     = 1'b0;
    bus.clear = 1'b0;
    bus.load  = 1'b0;
  endtask

  task automatic run_to_cnt(input int target);
    int n;
    n = 0;
    while (32'(bus.cur_count) != target && n < 40) begin
      step(0, 1, 0, 0, 0);
      n++;
    end
    chk("reach_cnt", 32'(bus.cur_count), 32'(target));
  endtask

  task automatic cycles_to_tick(input string tag, input int expected);
    int n;
    n = 0;
    do begin
      step(0, 1, 0, 0, 0);
      n++;
    end while (!bus.base_tick && n < 40);
    chk(tag, 32'(n), 32'(expected));
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.clear  = 1'b0;
    bus.load   = 1'b0;
    bus.div_in = '0;

    // Reset state
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_base",  32'(bus.base_tick),  32'd0);
    chk("rst_stage", 32'(bus.stage_tick), 32'd0);
    chk("rst_sq",    32'(bus.sq_out),     32'd0);
    chk("rst_cnt",   32'(bus.cur_count),  32'd0);

    // Free run from reset release: covers the 45-cycle stage 1 coincidence
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("first_tick_early", 32'(bus.base_tick), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("first_tick_c5", 32'(bus.base_tick), 32'd1);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0);
    chk("c45_base",   32'(bus.base_tick),  32'd1);
    chk("c45_stages", 32'(bus.stage_tick), 32'd3);

    // Load divisor 2 with cnt = 3
    run_to_cnt(3);
    step(0, 1, 0, 1, 2);
    chk("load_cnt0",   32'(bus.cur_count), 32'd0);
    chk("load_notick", 32'(bus.base_tick), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);

    // Divisor 0 (clamped) and 1: continuous ticks
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      chk("div0_cont", 32'(bus.base_tick), 32'd1);
    end
    step(0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      chk("div1_cont", 32'(bus.base_tick), 32'd1);
    end

    // Enable low for 7 cycles with cnt = 2, divisor back at 5
    step(0, 1, 0, 1, 5);
    run_to_cnt(2);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0);
      chk("hold_cnt", 32'(bus.cur_count), 32'd2);
    end
    cycles_to_tick("resume_latency", 3);

    // Load while enable is low is still honoured
    step(0, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 5);

    // Clear coincident with a wrap
    run_to_cnt(4);
    step(0, 1, 1, 0, 0);
    chk("clr_notick", 32'(bus.base_tick), 32'd0);
    chk("clr_sq",     32'(bus.sq_out),    32'd0);
    cycles_to_tick("clr_latency", 5);

    // Load and clear together
    step(0, 1, 1, 1, 3);
    cycles_to_tick("ldclr_latency", 3);

    // Reset mid-count after load of 9
    step(0, 1, 0, 1, 9);
    for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("mid_rst_cnt", 32'(bus.cur_count), 32'd0);
    chk("mid_rst_sq",  32'(bus.sq_out),    32'd0);
    cycles_to_tick("post_rst_period", 5);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 29) == 0),
           int'($urandom_range(0, 12)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
